// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the vector CPU fetch path.
// Opcodes are also decoded by the PC control unit.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_COM = 4'b0001;
  localparam logic [3:0] OP_END = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    COM,
    DONE,
    FAULT
  } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear beats enable.
// Used for the cycle counter and the COM timeout counter.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/exec_sequencer.sv
// Run controller: gates PC advance, drives the COM handshake
// with the host interpreter (with timeout) and the END halt.
module exec_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int             I       = 32,
  parameter int             T       = 16,
  parameter logic [T-1:0]   TIMEOUT = 16'd1000,
  parameter int             C       = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   Id,
  input  logic         StallReq,
  input  logic         ComAck,
  output logic         PCEnable,
  output logic         PCClear,
  output logic         ComReq,
  output logic         Running,
  output logic         Done,
  output logic         Fault,
  output logic [C-1:0] ComCount,
  output logic [I-1:0] CycleCount
);

  localparam logic [T-1:0] TMO_LAST = TIMEOUT - 1'b1;

  seq_state_t   state_q, state_d;
  logic         pcclear_q, pcclear_d;
  logic         comreq_q, comreq_d;
  logic         done_q, done_d;
  logic         fault_q, fault_d;
  logic [C-1:0] comcnt_q, comcnt_d;

  logic         launch;
  logic         pc_en;
  logic         tmo_clr;
  logic         tmo_en;
  logic         cyc_en;
  logic [T-1:0] tmo_cnt;

  always_comb begin
    state_d  = state_q;
    comcnt_d = comcnt_q;
    launch   = 1'b0;
    pc_en    = 1'b0;
    tmo_clr  = 1'b0;
    tmo_en   = 1'b0;
    unique case (state_q)
      IDLE, DONE, FAULT: begin
        if (start) begin
          state_d = RUN;
          launch  = 1'b1;
        end
      end
      RUN: begin
        if (Id == OP_END) begin
          state_d = DONE;
        end else if (Id == OP_COM) begin
          state_d = COM;
          tmo_clr = 1'b1;
        end else begin
          pc_en = !StallReq;
        end
      end
      COM: begin
        // ack wins over an expiring timeout in the same cycle
        if (ComAck) begin
          pc_en    = 1'b1;
          comcnt_d = comcnt_q + 1'b1;
          state_d  = RUN;
        end else begin
          tmo_en = 1'b1;
          if (tmo_cnt == TMO_LAST) begin
            state_d = FAULT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      comcnt_d = '0;
    end
    pcclear_d = launch;
    comreq_d  = (state_d == COM);
    done_d    = (state_d == DONE);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pcclear_q <= 1'b0;
      comreq_q  <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      comcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pcclear_q <= pcclear_d;
      comreq_q  <= comreq_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      comcnt_q  <= comcnt_d;
    end
  end

  assign cyc_en = (state_q == RUN) || (state_q == COM);

  sat_counter #(.W(I)) u_cyc_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (launch),
    .en_i    (cyc_en),
    .count_o (CycleCount)
  );

  sat_counter #(.W(T)) u_tmo_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (tmo_clr),
    .en_i    (tmo_en),
    .count_o (tmo_cnt)
  );

  assign PCEnable = pc_en;
  assign PCClear  = pcclear_q;
  assign ComReq   = comreq_q;
  assign Running  = cyc_en;
  assign Done     = done_q;
  assign Fault    = fault_q;
  assign ComCount = comcnt_q;

endmodule
